tty_ctrl: RTL and testbench

Character-stream controller for the TTY display, sitting directly upstream of the VGA text renderer. It accepts one character per bus write, interprets a small set of control codes, and keeps a cursor. It writes glyph codes into the character RAM's write port, which the VGA renderer reads through its other port. Scrolling is done by rotating a top-row pointer and blanking only the newly exposed line, so the frame buffer is never copied.

---
 rtl/tty_ctrl.sv | 133 +++++++++++++
 tb/tb_tty_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tty_ctrl.sv
// tty_ctrl - character-stream controller feeding the VGA text renderer's
// character RAM. Accepts one character per bus write, interprets CR, LF, BS
// and FF, keeps a cursor, and scrolls by rotating a top-row pointer while
// blanking only the newly exposed line.
//
// Ports:
//   clk_50mhz  system clock
//   rst        synchronous active-high reset (restarts the full-screen clear)
//   BUS        write data, character in BUS[7:0]
//   Memwrite   write strobe, accepted when busy=0
//   busy       high while a command executes or a clear runs
//   ram_we     character-RAM write enable
//   ram_addr   write address, row*COLS+col
//   ram_din    write data
//   top_row    buffer row shown on the first screen line
//   cur_row    cursor row (buffer coordinates)
//   cur_col    cursor column
module tty_ctrl #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic [31:0] BUS,
  input  logic        Memwrite,
  output logic        busy,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic [4:0]  top_row,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col
);

  typedef enum logic [1:0] {IDLE, EXEC, CLR_LINE, CLR_ALL} state_t;

  localparam logic [11:0] CELLS    = 12'(ROWS * COLS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

  state_t      state;
  logic [7:0]  ch;
  logic [11:0] clr_base;
  logic [11:0] clr_cnt;

  logic        printable, is_bs, do_nl, clearing;
  logic [6:0]  exec_col;
  logic [4:0]  last_vis, nxt_row, nxt_top;
  logic [11:0] cur_addr;
  logic        unused_bus;

  assign unused_bus = ^BUS[31:8];

  always_comb begin
    printable = (ch >= 8'h20) && (ch <= 8'h7E);
    is_bs     = (ch == 8'h08) && (cur_col != '0);
    do_nl     = (printable && (cur_col == LAST_COL)) || (ch == 8'h0A);
    clearing  = (state == CLR_LINE) || (state == CLR_ALL);
    // BS writes the blank at the position the cursor moves back to
    exec_col  = is_bs ? cur_col - 7'd1 : cur_col;
    cur_addr  = 12'(cur_row) * 12'(COLS) + 12'(exec_col);
    last_vis  = (top_row == '0) ? LAST_ROW : top_row - 5'd1;
    nxt_row   = (cur_row == LAST_ROW) ? '0 : cur_row + 5'd1;
    nxt_top   = (top_row == LAST_ROW) ? '0 : top_row + 5'd1;
  end

  // Outputs decode the registered state so a clear's first write lands in the
  // first cycle after entering the clear state (including right after reset).
  always_comb begin
    busy     = (state != IDLE);
    ram_we   = !rst && (clearing || ((state == EXEC) && (printable || is_bs)));
    ram_addr = clearing ? clr_base + clr_cnt : cur_addr;
    ram_din  = ((state == EXEC) && printable) ? ch : BLANK;
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state    <= CLR_ALL;
      ch       <= '0;
      clr_base <= '0;
      clr_cnt  <= '0;
      top_row  <= '0;
      cur_row  <= '0;
      cur_col  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Memwrite) begin
            ch    <= BUS[7:0];
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= IDLE;
          if (do_nl) begin
            cur_col <= '0;
            cur_row <= nxt_row;
            if (cur_row == last_vis) begin
              top_row  <= nxt_top;
              clr_base <= 12'(nxt_row) * 12'(COLS);
              clr_cnt  <= '0;
              state    <= CLR_LINE;
            end
          end else if (printable) begin
            cur_col <= cur_col + 7'd1;
          end else if (ch == 8'h0D) begin
            cur_col <= '0;
          end else if (is_bs) begin
            cur_col <= cur_col - 7'd1;
          end else if (ch == 8'h0C) begin
            top_row  <= '0;
            cur_row  <= '0;
            cur_col  <= '0;
            clr_base <= '0;
            clr_cnt  <= '0;
            state    <= CLR_ALL;
          end
        end
        CLR_LINE: begin
          clr_cnt <= clr_cnt + 12'd1;
          if (clr_cnt == 12'(COLS - 1)) state <= IDLE;
        end
        CLR_ALL: begin
          clr_cnt <= clr_cnt + 12'd1;
          if (clr_cnt == CELLS - 12'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tty_ctrl.sv
module tb_tty_ctrl;
  logic        clk_50mhz = 1'b0;
  logic        rst;
  logic [31:0] BUS;
  logic        Memwrite;
  logic        busy, ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic [4:0]  top_row, cur_row;
  logic [6:0]  cur_col;

  always #10 clk_50mhz = ~clk_50mhz;

  tty_ctrl #(.COLS(80), .ROWS(30), .BLANK(8'h20)) dut (
    .clk_50mhz(clk_50mhz), .rst(rst), .BUS(BUS), .Memwrite(Memwrite),
    .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .top_row(top_row), .cur_row(cur_row), .cur_col(cur_col)
  );

  typedef struct { int a; int d; } wr_t;
  wr_t q[$];
  int tests = 0;
  int fails = 0;
  int nwr   = 0;
  int bc;

  task automatic push(input int a, input int d);
    wr_t e;
    e.a = a; e.d = d;
    q.push_back(e);
  endtask

  task automatic push_blank(input int base, input int n);
    for (int i = 0; i < n; i++) push(base + i, 8'h20);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_cur(input string name, input int tr, input int r, input int c);
    chk({name, "_top"}, int'(top_row), tr);
    chk({name, "_row"}, int'(cur_row), r);
    chk({name, "_col"}, int'(cur_col), c);
  endtask

  // Scoreboard monitor: every RAM write must match the next expected entry.
  always @(negedge clk_50mhz) begin
    wr_t e;
    if (ram_we === 1'b1) begin
      nwr++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr %0d din %02h, no write expected", ram_addr, ram_din);
      end else begin
        e = q.pop_front();
        if (int'(ram_addr) != e.a || int'(ram_din) != e.d) begin
          fails++;
          $display("FAIL ram_write: addr %0d din %02h, expected addr %0d din %02h",
                   ram_addr, ram_din, e.a, e.d);
        end
      end
    end
  end

  task automatic wait_idle(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk_50mhz);
      if (busy !== 1'b1) break;
      cyc++;
      if (cyc > 5000) begin
        chk("busy_timeout", cyc, 0);
        break;
      end
    end
  endtask

  task automatic accept(input logic [7:0] c);
    @(negedge clk_50mhz);
    BUS = {24'h0, c};
    Memwrite = 1'b1;
    @(posedge clk_50mhz);
    #1 Memwrite = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, output int cyc);
    accept(c);
    wait_idle(cyc);
  endtask

  initial begin
    BUS = '0; Memwrite = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk_50mhz);
    #1;
    chk("rst_busy", int'(busy), 1);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_din", int'(ram_din), 8'h20);
    chk_cur("rst", 0, 0, 0);
    push_blank(0, 2400);
    nwr = 0;
    rst = 1'b0;
    wait_idle(bc);
    chk("reset_writes", nwr, 2400);
    chk("reset_busy_cycles", bc, 2400);
    chk("reset_queue", q.size(), 0);
    chk_cur("after_reset", 0, 0, 0);

    push(0, 8'h41);
    send(8'h41, bc);
    chk("A_busy", bc, 1);
    chk_cur("after_A", 0, 0, 1);

    for (int i = 1; i < 80; i++) begin
      push(i, 32 + i);
      send(8'(32 + i), bc);
    end
    chk("wrap_busy", bc, 1);
    chk_cur("row0_full", 0, 1, 0);
    chk("row0_queue", q.size(), 0);

    for (int i = 0; i < 28; i++) send(8'h0A, bc);
    chk("lf_busy", bc, 1);
    chk_cur("to_row29", 0, 29, 0);

    push(2320, 8'h5A);
    send(8'h5A, bc);
    chk_cur("Z_row29", 0, 29, 1);

    push_blank(0, 80);
    send(8'h0A, bc);
    chk("scroll_busy", bc, 81);
    chk_cur("after_scroll", 1, 0, 0);
    chk("scroll_queue", q.size(), 0);

    // FF with Memwrite pulses during the clear; none may be taken.
    push_blank(0, 2400);
    nwr = 0;
    fork
      send(8'h0C, bc);
      begin
        repeat (20) @(negedge clk_50mhz);
        repeat (3) begin
          BUS = 32'h51; Memwrite = 1'b1;
          @(negedge clk_50mhz);
          Memwrite = 1'b0;
          @(negedge clk_50mhz);
        end
      end
    join
    chk("ff_busy", bc, 2401);
    chk("ff_writes", nwr, 2400);
    chk("ff_queue", q.size(), 0);
    chk_cur("after_ff", 0, 0, 0);

    send(8'h0A, bc);
    send(8'h0A, bc);
    for (int i = 0; i < 5; i++) begin
      push(160 + i, 8'h61 + i);
      send(8'(8'h61 + i), bc);
    end
    chk_cur("at_2_5", 0, 2, 5);

    push(164, 8'h20);
    send(8'h08, bc);
    chk("bs_busy", bc, 1);
    chk_cur("after_bs", 0, 2, 4);
    send(8'h0D, bc);
    chk("cr_busy", bc, 1);
    chk_cur("after_cr", 0, 2, 0);
    send(8'h08, bc);
    chk("bs0_busy", bc, 1);
    chk_cur("after_bs0", 0, 2, 0);
    send(8'h07, bc);
    chk("bel_busy", bc, 1);
    chk_cur("after_bel", 0, 2, 0);

    // Reset in the middle of a scroll's line clear.
    for (int i = 0; i < 27; i++) send(8'h0A, bc);
    chk_cur("to_row29_b", 0, 29, 0);
    push_blank(0, 80);
    accept(8'h0A);
    repeat (40) @(negedge clk_50mhz);
    @(posedge clk_50mhz);
    #1 rst = 1'b1;
    q.delete();
    repeat (2) @(posedge clk_50mhz);
    #1;
    chk("midrst_busy", int'(busy), 1);
    chk("midrst_we", int'(ram_we), 0);
    chk("midrst_addr", int'(ram_addr), 0);
    chk_cur("midrst", 0, 0, 0);
    push_blank(0, 2400);
    nwr = 0;
    rst = 1'b0;
    wait_idle(bc);
    chk("midrst_writes", nwr, 2400);
    chk("midrst_queue", q.size(), 0);
    chk_cur("after_midrst", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
